// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl: buffers resolved branches from two commit slots and
// issues one BPU update per cycle, redirecting and flushing on mispredicts.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   c0_* / c1_*       commit slots (slot 0 older): valid, pc, taken,
//                     target, pred, pred_addr
//   cmt_ready         both slots can be accepted this cycle
//   upd_*             registered BPU update (valid, pc, addr, taken)
//   redirect_*        one-cycle fetch redirect with the correct next PC
//   flush_o           speculative pipeline flush, FLUSH_CYCLES long
//   br_cnt            branches sent to the BPU
//   mispred_cnt       mispredicts detected
module bpu_update_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        c0_valid,
  input  logic [31:0] c0_pc,
  input  logic        c0_taken,
  input  logic [31:0] c0_target,
  input  logic        c0_pred,
  input  logic [31:0] c0_pred_addr,

  input  logic        c1_valid,
  input  logic [31:0] c1_pc,
  input  logic        c1_taken,
  input  logic [31:0] c1_target,
  input  logic        c1_pred,
  input  logic [31:0] c1_pred_addr,

  output logic        cmt_ready,

  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_addr,
  output logic        upd_taken,

  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic        flush_o,

  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  // Highest occupancy that still leaves room for a dual commit.
  localparam logic [DEPTH-1:0] MAX_OCC = DEPTH'(DEPTH - 2);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] pred_addr;
    logic        taken;
    logic        pred;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [DEPTH-1:0] occ_q;
  state_e           state_q;
  logic [3:0]       fcnt_q;

  logic [AW-1:0]    wptr_d;
  logic [AW-1:0]    rptr_d;
  logic [DEPTH-1:0] occ_d;

  entry_t      ent0;
  entry_t      ent1;
  entry_t      head;
  logic        push0;
  logic        push1;
  logic        do_pop;
  logic        head_mis;
  logic        kill;
  logic [31:0] head_seq;
  logic [31:0] head_nxt;

  assign ent0 = '{pc: c0_pc, target: c0_target,
                  pred_addr: c0_pred_addr,
                  taken: c0_taken, pred: c0_pred};
  assign ent1 = '{pc: c1_pc, target: c1_target,
                  pred_addr: c1_pred_addr,
                  taken: c1_taken, pred: c1_pred};

  assign cmt_ready = (state_q != FLUSH) &&
                     (occ_q <= MAX_OCC);

  // Slot 1 is only meaningful behind a valid slot 0.
  assign push0 = cmt_ready && c0_valid;
  assign push1 = push0 && c1_valid;

  assign do_pop = (state_q != FLUSH) &&
                  (occ_q != '0);

  assign head     = mem_q[rptr_q];
  assign head_seq = head.pc + 32'd4;
  assign head_nxt = head.taken ? head.target
                               : head_seq;

  // A taken branch predicted taken can still
  // have fetched from the wrong target.
  assign head_mis =
    (head.taken != head.pred) ||
    (head.taken && (head.pred_addr != head.target));

  // Everything younger than a mispredict is
  // wrong-path, including same-edge pushes.
  assign kill = do_pop && head_mis;

  always_comb begin
    wptr_d = wptr_q + AW'(push0) + AW'(push1);
    rptr_d = rptr_q + AW'(do_pop);
    occ_d  = occ_q + DEPTH'(push0)
                   + DEPTH'(push1)
                   - DEPTH'(do_pop);
    if (kill) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end
  end

  // Storage needs no reset; occupancy alone
  // decides which entries are live.
  always_ff @(posedge clk) begin
    if (push0 && !kill)
      mem_q[wptr_q] <= ent0;
    if (push1 && !kill)
      mem_q[wptr_q + AW'(1)] <= ent1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      occ_q          <= '0;
      state_q        <= IDLE;
      fcnt_q         <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_addr       <= '0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      flush_o        <= 1'b0;
      br_cnt         <= '0;
      mispred_cnt    <= '0;
    end else begin
      upd_valid      <= 1'b0;
      redirect_valid <= 1'b0;

      case (state_q)
        FLUSH: begin
          if (fcnt_q == '0) begin
            flush_o <= 1'b0;
            state_q <= IDLE;
          end else begin
            fcnt_q <= fcnt_q - 4'd1;
          end
        end

        default: begin
          wptr_q <= wptr_d;
          rptr_q <= rptr_d;
          occ_q  <= occ_d;

          if (do_pop) begin
            upd_valid <= 1'b1;
            upd_pc    <= head.pc;
            upd_addr  <= head_nxt;
            upd_taken <= head.taken;
            br_cnt    <= br_cnt + 32'd1;
          end

          if (kill) begin
            redirect_valid <= 1'b1;
            redirect_addr  <= head_nxt;
            mispred_cnt    <= mispred_cnt + 32'd1;
            flush_o        <= 1'b1;
            fcnt_q         <= FLUSH_LOAD;
            state_q        <= FLUSH;
          end else if (occ_d == '0) begin
            state_q <= IDLE;
          end else begin
            state_q <= DRAIN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// tb_bpu_update_ctrl: directed plus random stimulus for bpu_update_ctrl,
// checked every cycle against a queue-based reference model.
module tb_bpu_update_ctrl;

  localparam int DEPTH = 4;
  localparam int FLC   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_valid, c0_taken, c0_pred;
  logic [31:0] c0_pc, c0_target, c0_pred_addr;
  logic        c1_valid, c1_taken, c1_pred;
  logic [31:0] c1_pc, c1_target, c1_pred_addr;
  logic        cmt_ready;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_addr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        flush_o;
  logic [31:0] br_cnt, mispred_cnt;

  bpu_update_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLC)) dut (
    .clk(clk), .rst(rst),
    .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_taken(c0_taken),
    .c0_target(c0_target), .c0_pred(c0_pred),
    .c0_pred_addr(c0_pred_addr),
    .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_taken(c1_taken),
    .c1_target(c1_target), .c1_pred(c1_pred),
    .c1_pred_addr(c1_pred_addr),
    .cmt_ready(cmt_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_addr(upd_addr), .upd_taken(upd_taken),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .flush_o(flush_o),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, tgt, pa;
    logic        tk, pr;
  } br_t;

  br_t         q[$];
  int          fl;
  logic        e_upd, e_utk, e_redir, e_flush;
  logic [31:0] e_upc, e_uaddr, e_raddr, e_br, e_mis;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return (fl == 0) && (q.size() <= DEPTH - 2);
  endfunction

  function automatic logic [31:0] nxt(br_t b);
    return b.tk ? b.tgt : b.pc + 32'd4;
  endfunction

  task automatic model_reset();
    q.delete();
    fl = 0;
    {e_upd, e_utk, e_redir, e_flush} = '0;
    {e_upc, e_uaddr, e_raddr, e_br, e_mis} = '0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    logic rdy, mis;
    br_t  b;
    if (rst) begin
      model_reset();
      return;
    end
    rdy     = m_ready();
    mis     = 1'b0;
    e_upd   = 1'b0;
    e_redir = 1'b0;
    if (fl > 0) begin
      fl--;
    end else begin
      if (q.size() > 0) begin
        b       = q.pop_front();
        e_upd   = 1'b1;
        e_upc   = b.pc;
        e_uaddr = nxt(b);
        e_utk   = b.tk;
        e_br    = e_br + 1;
        if (b.tk != b.pr || (b.tk && b.pa != b.tgt)) begin
          mis     = 1'b1;
          e_redir = 1'b1;
          e_raddr = nxt(b);
          e_mis   = e_mis + 1;
          fl      = FLC;
          q.delete();
        end
      end
      if (rdy && !mis && c0_valid) begin
        q.push_back('{c0_pc, c0_target, c0_pred_addr,
                      c0_taken, c0_pred});
        if (c1_valid)
          q.push_back('{c1_pc, c1_target, c1_pred_addr,
                        c1_taken, c1_pred});
      end
    end
    e_flush = (fl > 0);
  endtask

  task automatic check_all();
    chk("upd_valid", upd_valid, e_upd);
    if (e_upd) begin
      chk("upd_pc", upd_pc, e_upc);
      chk("upd_addr", upd_addr, e_uaddr);
      chk("upd_taken", upd_taken, e_utk);
    end
    chk("redirect_valid", redirect_valid, e_redir);
    if (e_redir)
      chk("redirect_addr", redirect_addr, e_raddr);
    chk("flush_o", flush_o, e_flush);
    chk("br_cnt", br_cnt, e_br);
    chk("mispred_cnt", mispred_cnt, e_mis);
    chk("cmt_ready", cmt_ready, m_ready());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set0(input logic v, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tg,
                      input logic pr, input logic [31:0] pa);
    c0_valid = v; c0_pc = pc; c0_taken = tk;
    c0_target = tg; c0_pred = pr; c0_pred_addr = pa;
  endtask

  task automatic set1(input logic v, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tg,
                      input logic pr, input logic [31:0] pa);
    c1_valid = v; c1_pc = pc; c1_taken = tk;
    c1_target = tg; c1_pred = pr; c1_pred_addr = pa;
  endtask

  task automatic idle();
    set0(0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int sent;
    int it;
    logic [31:0] pc, tg;
    logic tk;
    model_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    chk("rst_ready", cmt_ready, 1'b1);
    chk("rst_flush", flush_o, 1'b0);

    // Single correct branch.
    set0(1, 32'h100, 1, 32'h200, 1, 32'h200);
    step();
    idle();
    step();
    chk("single_pc", upd_pc, 32'h100);
    chk("single_addr", upd_addr, 32'h200);
    chk("single_br", br_cnt, 32'd1);
    step();

    // Dual commit, both correct.
    set0(1, 32'h10, 0, 32'h999, 0, 32'h0);
    set1(1, 32'h20, 1, 32'h40, 1, 32'h40);
    step();
    idle();
    step();
    chk("dual0_addr", upd_addr, 32'h14);
    step();
    chk("dual1_addr", upd_addr, 32'h40);
    chk("dual_br", br_cnt, 32'd3);
    step();

    // Slot-0 mispredict with a wrong-path slot 1.
    set0(1, 32'h30, 1, 32'h80, 0, 32'h0);
    set1(1, 32'h34, 0, 32'h0, 0, 32'h0);
    step();
    idle();
    step();
    chk("mis_redir", redirect_addr, 32'h80);
    chk("mis_cnt", mispred_cnt, 32'd1);
    repeat (5) step();

    // Target mismatch, then reset in the middle of its flush.
    set0(1, 32'h50, 1, 32'hA0, 1, 32'h90);
    step();
    idle();
    step();
    chk("tgt_redir", redirect_addr, 32'hA0);
    step();
    chk("tgt_flush", flush_o, 1'b1);
    do_reset();
    chk("mid_flush_ready", cmt_ready, 1'b1);
    chk("mid_flush_br", br_cnt, 32'd0);
    chk("mid_flush_mis", mispred_cnt, 32'd0);

    // Backpressure: upstream holds a pair until it is accepted.
    sent = 0;
    it = 0;
    while (sent < 8 && it < 100) begin
      set0(1, 32'h1000 + 16 * sent, 0, 32'h0, 0, 32'h0);
      set1(1, 32'h1008 + 16 * sent, 1, 32'h3000 + sent,
           1, 32'h3000 + sent);
      if (m_ready()) sent++;
      step();
      it++;
    end
    if (it >= 100) chk("bp_stall", sent, 8);
    idle();
    repeat (6) step();
    chk("bp_br", br_cnt, 32'd16);
    chk("bp_mis", mispred_cnt, 32'd0);

    // Random traffic with occasional mispredicts and resets.
    repeat (2000) begin
      tk = 1'($urandom);
      tg = $urandom;
      pc = $urandom;
      set0(($urandom % 4) != 0, pc, tk, tg,
           ($urandom % 12 == 0) ? ~tk : tk,
           ($urandom % 12 == 0) ? $urandom : tg);
      tk = 1'($urandom);
      tg = $urandom;
      set1(1'($urandom), pc + 4, tk, tg,
           ($urandom % 12 == 0) ? ~tk : tk,
           ($urandom % 12 == 0) ? $urandom : tg);
      rst = ($urandom % 400 == 0);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
